// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// Shares one pipelined Wishbone slave between NUM_MASTERS pipelined Wishbone
// masters using round-robin arbitration. The slave is typically the DDR3
// framebuffer bus (or its simulation memory stand-in). Typical masters are
// the core data port and the HDMI framebuffer reader.
//
// The owner keeps the grant for a whole bus cycle, that is, for as long as it
// holds cyc high. There is no preemption. Accepted requests that have not yet
// been answered are counted, for two reasons:
//   - responses are routed only to the owner while its cycle is open;
//   - the number of requests in flight never exceeds MAX_OUTSTANDING.
//
// Parameters
//   NUM_MASTERS      number of requesting masters (>= 2)
//   ADDRESS_WIDTH    Wishbone word-address width
//   DATA_WIDTH       Wishbone data width (multiple of 8)
//   MAX_OUTSTANDING  max accepted-but-unanswered requests (>= 1)
//
// Ports
//   clk_i, reset_i           clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i   per-master controls, one bit per master
//   m_addr_i                 per-master address, master i at [i*AW +: AW]
//   m_sel_i                  per-master byte selects, master i at [i*DW/8 +: DW/8]
//   m_wdata_i                per-master write data, master i at [i*DW +: DW]
//   m_rdata_o                slave read data, broadcast to every master
//   m_ack_o/m_err_o/m_rty_o  responses, driven only toward the owner
//   m_stall_o                per-master stall (all high when idle)
//   s_cyc_o/s_stb_o/s_we_o   slave-side controls
//   s_addr_o/s_sel_o/s_wdata_o  slave request payload, muxed from the owner
//   s_rdata_i                slave read data
//   s_ack_i/s_err_i/s_rty_i/s_stall_i  slave responses and stall
//   grant_o                  one-hot owner, zero while idle
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  // master side
  input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]    m_sel_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic [NUM_MASTERS-1:0]                 m_ack_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic [NUM_MASTERS-1:0]                 m_rty_o,
  output logic [NUM_MASTERS-1:0]                 m_stall_o,
  // slave side
  output logic                                   s_cyc_o,
  output logic                                   s_stb_o,
  output logic                                   s_we_o,
  output logic [ADDRESS_WIDTH-1:0]               s_addr_o,
  output logic [DATA_WIDTH/8-1:0]                s_sel_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  input  logic                                   s_ack_i,
  input  logic                                   s_err_i,
  input  logic                                   s_rty_i,
  input  logic                                   s_stall_i,
  // status
  output logic [NUM_MASTERS-1:0]                 grant_o
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE,
    S_GRANTED
  } state_t;

  state_t          r_state, w_state_next;
  logic [OW-1:0]   r_owner, w_owner_next;
  logic [OW-1:0]   r_last,  w_last_next;
  logic [CW-1:0]   r_count, w_count_next;

  logic            w_granted;
  logic            w_cyc_g;
  logic            w_full;
  logic            w_resp;
  logic            w_issue;
  logic            w_retire;

  // Pick the first requester found by searching upward (mod N) from
  // last+1. The loop runs from the farthest offset down to the nearest, so
  // the nearest requester is written last and wins. Offset N is the previous
  // owner itself, which therefore has the lowest priority.
  function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0]          last,
                                            input logic [NUM_MASTERS-1:0] req);
    logic [OW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (req[idx]) pick = OW'(idx);
    end
    return pick;
  endfunction

  // -------------------------------------------------------------------------
  // Datapath and qualifiers
  // -------------------------------------------------------------------------
  assign w_granted = (r_state == S_GRANTED);
  assign w_full    = (r_count == CW'(MAX_OUTSTANDING));
  assign w_cyc_g   = w_granted & m_cyc_i[r_owner];
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;

  // stb is gated by the owner's cyc, so a stray stb from a master that has
  // already dropped cyc never reaches the slave.
  assign s_cyc_o   = w_cyc_g;
  assign s_stb_o   = w_cyc_g & m_stb_i[r_owner] & ~w_full;
  assign s_we_o    = m_we_i[r_owner];
  assign s_addr_o  = m_addr_i[int'(r_owner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign s_sel_o   = m_sel_i[int'(r_owner)*SW +: SW];
  assign s_wdata_o = m_wdata_i[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign m_rdata_o = s_rdata_i;

  assign w_issue   = s_stb_o & ~s_stall_i;
  // A response with nothing outstanding is ignored, so the count cannot wrap.
  assign w_retire  = w_cyc_g & w_resp & (r_count != '0);

  // -------------------------------------------------------------------------
  // Master-side response, stall and grant routing
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_o   = '0;
    m_stall_o = '1;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    if (w_granted) begin
      grant_o[r_owner]   = 1'b1;
      m_stall_o[r_owner] = s_stall_i | w_full;
      // Gating with s_cyc_o drops responses that arrive after the owner
      // has closed its cycle.
      m_ack_o[r_owner]   = s_ack_i & w_cyc_g;
      m_err_o[r_owner]   = s_err_i & w_cyc_g;
      m_rty_o[r_owner]   = s_rty_i & w_cyc_g;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state, owner/last-grant bookkeeping, outstanding count
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (|m_cyc_i) begin
          w_state_next = S_GRANTED;
          w_owner_next = rr_pick(r_last, m_cyc_i);
        end
      end
      S_GRANTED: begin
        if (!m_cyc_i[r_owner]) begin
          // Release: anything still in flight is abandoned. The pass
          // through IDLE guarantees that the slave sees cyc low between
          // two owners.
          w_state_next = S_IDLE;
          w_last_next  = r_owner;
          w_count_next = '0;
        end else if (w_issue && !w_retire) begin
          w_count_next = r_count + CW'(1);
        end else if (!w_issue && w_retire) begin
          w_count_next = r_count - CW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge, in any block order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= OW'(NUM_MASTERS - 1);
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_count <= w_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Simulation-only checks (ignored by synthesis)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(w_cyc_g && w_resp && (r_count == '0)))
        else $warning("wb_rr_arbiter: slave response with nothing outstanding ignored");
      assert (r_count <= CW'(MAX_OUTSTANDING))
        else $error("wb_rr_arbiter: outstanding count above limit");
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0]   a_addr  [N];
  logic [SW-1:0]   a_sel   [N];
  logic [DW-1:0]   a_wdata [N];
  logic [N*AW-1:0] m_addr_p;
  logic [N*SW-1:0] m_sel_p;
  logic [N*DW-1:0] m_wdata_p;

  logic [DW-1:0]   m_rdata_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, m_stall_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_wdata_o;
  logic [DW-1:0]   sl_rdata;
  logic            sl_ack, sl_err, sl_rty, sl_stall;

  always_comb begin
    m_addr_p  = '0;
    m_sel_p   = '0;
    m_wdata_p = '0;
    for (int i = 0; i < N; i++) begin
      m_addr_p[i*AW +: AW]  = a_addr[i];
      m_sel_p[i*SW +: SW]   = a_sel[i];
      m_wdata_p[i*DW +: DW] = a_wdata[i];
    end
  end

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_addr_i(m_addr_p), .m_sel_i(m_sel_p), .m_wdata_i(m_wdata_p),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(sl_rdata), .s_ack_i(sl_ack), .s_err_i(sl_err),
    .s_rty_i(sl_rty), .s_stall_i(sl_stall),
    .grant_o(grant_o)
  );

  // Reference model: owner (-1 = no bus cycle), last owner, requests in flight
  int mod_owner, mod_last, mod_cnt;
  int n_tests = 0;
  int n_fail  = 0;
  int acks_seen [N];
  int stb_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mod_owner = -1;
    mod_last  = N - 1;
    mod_cnt   = 0;
  endtask

  task automatic model_update();
    int g;
    bit issue, resp, found;
    if (reset_i) begin
      model_reset();
    end else if (mod_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        g = (mod_last + k) % N;
        if (!found && m_cyc[g]) begin
          mod_owner = g;
          found = 1;
        end
      end
    end else begin
      g = mod_owner;
      if (!m_cyc[g]) begin
        mod_last  = g;
        mod_owner = -1;
        mod_cnt   = 0;
      end else begin
        issue = m_stb[g] && (mod_cnt < MAXO) && !sl_stall;
        resp  = (sl_ack || sl_err || sl_rty) && (mod_cnt > 0);
        mod_cnt = mod_cnt + int'(issue) - int'(resp);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e_grant, e_stall, e_ack, e_err, e_rty;
    logic e_cyc, e_stb;
    int g;
    e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0;
    g = mod_owner;
    if (g >= 0) begin
      e_grant[g] = 1'b1;
      e_cyc      = m_cyc[g];
      e_stb      = e_cyc & m_stb[g] & (mod_cnt < MAXO);
      e_stall[g] = sl_stall | (mod_cnt == MAXO);
      e_ack[g]   = sl_ack & e_cyc;
      e_err[g]   = sl_err & e_cyc;
      e_rty[g]   = sl_rty & e_cyc;
    end
    check($sformatf("%s grant", tag), grant_o, e_grant);
    check($sformatf("%s s_cyc/stb", tag), {s_cyc_o, s_stb_o}, {e_cyc, e_stb});
    check($sformatf("%s stall", tag), m_stall_o, e_stall);
    check($sformatf("%s ack/err/rty", tag), {m_ack_o, m_err_o, m_rty_o}, {e_ack, e_err, e_rty});
    check($sformatf("%s rdata", tag), m_rdata_o, sl_rdata);
    if (e_cyc) begin
      check($sformatf("%s we", tag), s_we_o, m_we[g]);
      check($sformatf("%s addr", tag), s_addr_o, a_addr[g]);
      check($sformatf("%s sel", tag), s_sel_o, a_sel[g]);
      check($sformatf("%s wdata", tag), s_wdata_o, a_wdata[g]);
    end
    for (int i = 0; i < N; i++) if (m_ack_o[i] === 1'b1) acks_seen[i]++;
    if (s_stb_o === 1'b1 && !sl_stall) stb_seen++;
  endtask

  // Called at posedge+1 with inputs already set; checks, clocks, updates the model.
  task automatic step(input string tag);
    sl_rdata = $urandom;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we);
    m_cyc[i]   = cyc;
    m_stb[i]   = stb;
    m_we[i]    = we;
    a_addr[i]  = $urandom;
    a_sel[i]   = SW'($urandom);
    a_wdata[i] = $urandom;
  endtask

  task automatic slave(input logic ack, input logic stall);
    sl_ack = ack; sl_err = 1'b0; sl_rty = 1'b0; sl_stall = stall;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 1'b0);
    slave(1'b0, 1'b0);
    step("reset");
    step("reset");
    reset_i = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) acks_seen[i] = 0;
    stb_seen = 0;
  endtask

  initial begin
    int r;
    reset_i = 1'b1;
    sl_rdata = '0;
    model_reset();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 1'b0);
    slave(1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    #1;
    check("rst grant", grant_o, 2'b00);
    check("rst stall", m_stall_o, 2'b11);
    check("rst s_cyc/stb", {s_cyc_o, s_stb_o}, 2'b00);
    check("rst resp", {m_ack_o, m_err_o, m_rty_o}, 6'd0);

    // 1: single master, 4 back-to-back reads, slave acks one cycle later
    clear_counts();
    set_m(0, 1'b1, 1'b1, 1'b0);
    step("t1 req");
    check("t1 grant after 1 cycle", grant_o, 2'b01);
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1'b1, 1'b1, 1'b0);
      slave(mod_cnt > 0, 1'b0);
      step("t1 read");
    end
    set_m(0, 1'b1, 1'b0, 1'b0);
    slave(mod_cnt > 0, 1'b0);
    step("t1 last ack");
    slave(1'b0, 1'b0);
    check("t1 acks to m0", acks_seen[0], 4);
    check("t1 acks to m1", acks_seen[1], 0);
    set_m(0, 1'b0, 1'b0, 1'b0);
    step("t1 release");

    // 2: simultaneous requests from reset
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0);
    set_m(1, 1'b1, 1'b0, 1'b0);
    step("t2 req");
    check("t2 first grant", grant_o, 2'b01);
    step("t2 hold");
    step("t2 hold");
    set_m(0, 1'b0, 1'b0, 1'b0);
    step("t2 release");
    check("t2 idle gap", grant_o, 2'b00);
    step("t2 idle");
    check("t2 second grant", grant_o, 2'b10);

    // 3: outstanding limit with a withholding slave
    set_m(1, 1'b0, 1'b0, 1'b0);
    set_m(0, 1'b1, 1'b0, 1'b0);
    step("t3 release m1");
    step("t3 idle");
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1'b1, 1'b1, 1'b0);
      step("t3 stb");
    end
    check("t3 accepted", stb_seen, 4);
    #1;
    check("t3 stall at limit", m_stall_o[0], 1'b1);
    slave(1'b1, 1'b0);
    step("t3 ack");
    slave(1'b0, 1'b0);
    stb_seen = 0;
    for (int i = 0; i < 3; i++) step("t3 after ack");
    check("t3 one more accepted", stb_seen, 1);

    // 4: simultaneous issue+response keeps count; response at count 0 ignored
    set_m(0, 1'b1, 1'b0, 1'b0);
    slave(1'b1, 1'b0);
    step("t4 drain");
    step("t4 drain");
    set_m(0, 1'b1, 1'b1, 1'b0);
    step("t4 ack+stb");
    slave(1'b0, 1'b0);
    stb_seen = 0;
    for (int i = 0; i < 4; i++) step("t4 fill");
    check("t4 count stayed 2", stb_seen, 2);
    set_m(0, 1'b1, 1'b0, 1'b0);
    slave(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("t4 drain all");
    step("t4 ack at zero");
    slave(1'b0, 1'b0);
    stb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      set_m(0, 1'b1, 1'b1, 1'b0);
      step("t4 refill");
    end
    check("t4 no underflow", stb_seen, 4);

    // 5: owner drops cyc with requests in flight; late acks discarded
    set_m(0, 1'b1, 1'b0, 1'b0);
    slave(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("t5 drain");
    slave(1'b0, 1'b0);
    set_m(0, 1'b0, 1'b0, 1'b0);
    set_m(1, 1'b1, 1'b0, 1'b0);
    step("t5 release m0");
    step("t5 idle");
    check("t5 m1 granted", grant_o, 2'b10);
    for (int i = 0; i < 2; i++) begin
      set_m(1, 1'b1, 1'b1, 1'b1);
      step("t5 m1 write");
    end
    set_m(1, 1'b0, 1'b0, 1'b0);
    set_m(0, 1'b1, 1'b0, 1'b0);
    clear_counts();
    slave(1'b1, 1'b0);
    step("t5 drop with 2 out");
    step("t5 late ack");
    slave(1'b0, 1'b0);
    check("t5 late acks m0", acks_seen[0], 0);
    check("t5 late acks m1", acks_seen[1], 0);
    check("t5 m0 granted", grant_o, 2'b01);
    stb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      set_m(0, 1'b1, 1'b1, 1'b0);
      step("t5 count cleared");
    end
    check("t5 count restarted at 0", stb_seen, 4);

    // 6: asynchronous reset while granted with 3 outstanding
    set_m(0, 1'b1, 1'b0, 1'b0);
    slave(1'b1, 1'b0);
    step("t6 to 3");
    slave(1'b0, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6 async s_cyc", s_cyc_o, 1'b0);
    check("t6 async grant", grant_o, 2'b00);
    check("t6 async stall", m_stall_o, 2'b11);
    model_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    step("t6 re-request");
    check("t6 regrant", grant_o, 2'b01);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i]) begin
          if ($urandom_range(19) == 0) set_m(i, 1'b0, 1'b0, 1'b0);
          else set_m(i, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end else if ($urandom_range(3) == 0) begin
          set_m(i, 1'b1, 1'b0, 1'b0);
        end
      end
      slave(1'b0, $urandom_range(3) == 0);
      if (mod_owner >= 0 && mod_cnt > 0 && $urandom_range(1) == 1) begin
        r = $urandom_range(7);
        if (r < 6) sl_ack = 1'b1;
        else if (r == 6) sl_err = 1'b1;
        else sl_rty = 1'b1;
      end else if (mod_owner < 0 && $urandom_range(7) == 0) begin
        sl_ack = 1'b1;
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
